// File: rtl/conv_row_sequencer.sv
// Steps a full-image convolution pass one output row at a time and offers each finished row downstream.
// Optional COMPUTE watchdog: define CONV_ROW_SEQ_WATCHDOG_EN.
module conv_row_sequencer #(
    parameter int H       = 32,
    parameter int W       = 32,
    parameter int F       = 5,
    parameter int SETTLE  = 1,
    parameter int TIMEOUT = 1023
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       start,
    output logic       busy,
    output logic       done,
    output logic [5:0] rowNumber,
    output logic       convEn,
    input  logic       convDone,
    output logic       rowValid,
    input  logic       rowReady,
    output logic [5:0] rowIndex,
    output logic       error
);

    localparam int              SW          = (SETTLE > 1) ? $clog2(SETTLE) : 1;
    localparam logic [SW-1:0]   SETTLE_LAST = SW'(SETTLE - 1);
    localparam logic [5:0]      LAST_ROW    = 6'(H - F);

    // The row select is only 6 bits wide and the watchdog counter only 10 bits wide.
    if ((H - F) > 63 || F > H || F > W || SETTLE < 1 || TIMEOUT < 1 || TIMEOUT > 1023) begin : gBadParams
        $error("conv_row_sequencer: unsupported parameter combination");
    end

    typedef enum logic [2:0] {
        S_IDLE,
        S_SETTLE,
        S_COMPUTE,
        S_EMIT,
        S_FINISH
    } state_t;

    state_t        state;
    logic [SW-1:0] settleCount;

`ifdef CONV_ROW_SEQ_WATCHDOG_EN
    localparam logic [9:0] TIMEOUT_LAST = 10'(TIMEOUT - 1);
    logic [9:0] wdCount;
    logic       errorReg;
    assign error = errorReg;
`else
    assign error = 1'b0;
`endif

    // All outputs are registered; rowNumber only moves on start or when a handed-off row leads to the next.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state       <= S_IDLE;
            busy        <= 1'b0;
            done        <= 1'b0;
            rowNumber   <= 6'd0;
            convEn      <= 1'b0;
            rowValid    <= 1'b0;
            rowIndex    <= 6'd0;
            settleCount <= '0;
`ifdef CONV_ROW_SEQ_WATCHDOG_EN
            wdCount     <= 10'd0;
            errorReg    <= 1'b0;
`endif
        end else begin
            done <= 1'b0;
            case (state)
                S_IDLE: begin
                    if (start) begin
                        state       <= S_SETTLE;
                        busy        <= 1'b1;
                        rowNumber   <= 6'd0;
                        settleCount <= '0;
`ifdef CONV_ROW_SEQ_WATCHDOG_EN
                        errorReg    <= 1'b0;
`endif
                    end
                end

                S_SETTLE: begin
                    if (settleCount == SETTLE_LAST) begin
                        state  <= S_COMPUTE;
                        convEn <= 1'b1;
`ifdef CONV_ROW_SEQ_WATCHDOG_EN
                        wdCount <= 10'd0;
`endif
                    end else begin
                        settleCount <= settleCount + SW'(1);
                    end
                end

                S_COMPUTE: begin
                    if (convDone) begin
                        state    <= S_EMIT;
                        convEn   <= 1'b0;
                        rowValid <= 1'b1;
                        rowIndex <= rowNumber;
                    end
`ifdef CONV_ROW_SEQ_WATCHDOG_EN
                    else if (wdCount == TIMEOUT_LAST) begin
                        state    <= S_IDLE;
                        convEn   <= 1'b0;
                        busy     <= 1'b0;
                        errorReg <= 1'b1;
                    end else begin
                        wdCount <= wdCount + 10'd1;
                    end
`endif
                end

                S_EMIT: begin
                    if (rowReady) begin
                        rowValid <= 1'b0;
                        if (rowNumber == LAST_ROW) begin
                            state <= S_FINISH;
                            busy  <= 1'b0;
                            done  <= 1'b1;
                        end else begin
                            state       <= S_SETTLE;
                            rowNumber   <= rowNumber + 6'd1;
                            settleCount <= '0;
                        end
                    end
                end

                S_FINISH: begin
                    state <= S_IDLE;
                end

                default: begin
                    state <= S_IDLE;
                end
            endcase
        end
    end

endmodule
